// File: rtl/trap_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// trap_sequencer_pkg
// Shared types for the writeback trap/flush sequencer.
//   ecause_t      : exception cause code carried from writeback to mcause.
//   trap_state_t  : sequencer FSM states.
//   trap_kind_t   : kind of event captured in IDLE.
// ----------------------------------------------------------------------------
package trap_sequencer_pkg;

    typedef logic [3:0] ecause_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        FLUSH,
        REDIRECT
    } trap_state_t;

    typedef enum logic [1:0] {
        TK_EXC,
        TK_MRET,
        TK_FLUSH
    } trap_kind_t;

endpackage

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
// Sequences the writeback boundary for an exception, an mret or a flush
// request: drain in-flight bus transactions, commit trap CSRs (exceptions
// only), squash the pipeline for one cycle, then hand a new pc to fetch.
//
// Optional build macro: TRAP_SEQ_COUNT_EN enables the saturating trap_count
// counter; without it trap_count is tied to zero.
//
// Ports:
//   clk_core, reset          core clock, asynchronous active-high reset
//   wb_exc/wb_mret/wb_flush  retiring-instruction events (exc > mret > flush)
//   wb_exc_cause, wb_pc      cause and pc of the retiring instruction
//   fe1_stall, mem1_stall    outstanding fetch / memory cache fills
//   csr_mtvec, csr_mepc      trap vector base and mret return pc
//   seq_busy                 pipeline hold, high whenever state != IDLE
//   seq_flush                one-cycle pipeline squash
//   csr_trap_we              one-cycle mepc/mcause write strobe
//   csr_mepc_wdata           captured wb_pc
//   csr_mcause_wdata         captured cause
//   redirect_valid/ready/pc  redirect handshake towards fetch
//   drain_timeout            sticky flag: drain exceeded DRAIN_MAX cycles
//   trap_count               number of committed traps (optional)
// ----------------------------------------------------------------------------
import trap_sequencer_pkg::*;

module trap_sequencer #(
    parameter int DRAIN_MAX = 64,
    parameter int CNT_W     = 7
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        wb_exc,
    input  ecause_t     wb_exc_cause,
    input  logic        wb_flush,
    input  logic        wb_mret,
    input  logic [31:2] wb_pc,
    input  logic        fe1_stall,
    input  logic        mem1_stall,
    input  logic [31:2] csr_mtvec,
    input  logic [31:2] csr_mepc,
    output logic        seq_busy,
    output logic        seq_flush,
    output logic        csr_trap_we,
    output logic [31:2] csr_mepc_wdata,
    output ecause_t     csr_mcause_wdata,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:2] redirect_pc,
    output logic        drain_timeout,
    output logic [31:0] trap_count
);

    trap_state_t      state;
    trap_kind_t       kind;
    logic [CNT_W-1:0] drain_cnt;

    // drain_cnt holds the 1-based index of the current DRAIN cycle, so the
    // timeout flag becomes visible in DRAIN cycle DRAIN_MAX.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            kind             <= TK_EXC;
            drain_cnt        <= '0;
            seq_busy         <= 1'b0;
            seq_flush        <= 1'b0;
            csr_trap_we      <= 1'b0;
            csr_mepc_wdata   <= '0;
            csr_mcause_wdata <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            drain_timeout    <= 1'b0;
        end else begin
            seq_flush   <= 1'b0;
            csr_trap_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_exc || wb_mret || wb_flush) begin
                        state            <= DRAIN;
                        seq_busy         <= 1'b1;
                        drain_cnt        <= CNT_W'(1);
                        csr_mepc_wdata   <= wb_pc;
                        csr_mcause_wdata <= wb_exc_cause;
                        // Target is resolved at capture so later CSR writes
                        // cannot disturb an in-progress sequence.
                        if (wb_exc) begin
                            kind        <= TK_EXC;
                            redirect_pc <= csr_mtvec;
                        end else if (wb_mret) begin
                            kind        <= TK_MRET;
                            redirect_pc <= csr_mepc;
                        end else begin
                            kind        <= TK_FLUSH;
                            redirect_pc <= wb_pc + 30'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!fe1_stall && !mem1_stall) begin
                        drain_cnt <= '0;
                        if (kind == TK_EXC) begin
                            state       <= COMMIT;
                            csr_trap_we <= 1'b1;
                        end else begin
                            state     <= FLUSH;
                            seq_flush <= 1'b1;
                        end
                    end else begin
                        if (drain_cnt != '1) begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                        if (drain_cnt >= CNT_W'(DRAIN_MAX - 1)) begin
                            drain_timeout <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state     <= FLUSH;
                    seq_flush <= 1'b1;
                end
                FLUSH: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        seq_busy       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    seq_busy       <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRAP_SEQ_COUNT_EN
    logic [31:0] trap_cnt;

    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            trap_cnt <= '0;
        end else if (state == COMMIT && trap_cnt != 32'hFFFF_FFFF) begin
            trap_cnt <= trap_cnt + 32'd1;
        end
    end

    assign trap_count = trap_cnt;
`else
    assign trap_count = 32'd0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    logic        clk_core = 1'b0;
    logic        reset = 1'b1;
    logic        wb_exc = 1'b0, wb_flush = 1'b0, wb_mret = 1'b0;
    ecause_t     wb_exc_cause = '0;
    logic [31:2] wb_pc = '0;
    logic        fe1_stall = 1'b0, mem1_stall = 1'b0;
    logic [31:2] csr_mtvec = '0, csr_mepc = '0;
    logic        seq_busy, seq_flush, csr_trap_we;
    logic [31:2] csr_mepc_wdata;
    ecause_t     csr_mcause_wdata;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:2] redirect_pc;
    logic        drain_timeout;
    logic [31:0] trap_count;

    trap_sequencer #(.DRAIN_MAX(64), .CNT_W(7)) dut (
        .clk_core(clk_core), .reset(reset),
        .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause), .wb_flush(wb_flush),
        .wb_mret(wb_mret), .wb_pc(wb_pc),
        .fe1_stall(fe1_stall), .mem1_stall(mem1_stall),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .seq_busy(seq_busy), .seq_flush(seq_flush), .csr_trap_we(csr_trap_we),
        .csr_mepc_wdata(csr_mepc_wdata), .csr_mcause_wdata(csr_mcause_wdata),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .drain_timeout(drain_timeout),
        .trap_count(trap_count)
    );

    always #5 clk_core = ~clk_core;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          commit;
        logic [29:0] mepc;
        ecause_t     cause;
        logic [29:0] pc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    // Observations of one sequence, cycle 1 = first cycle after the event edge.
    int          commit_cyc, flush_cyc, redir_cyc, end_cyc, commits, flushes, to_first;
    logic [29:0] obs_mepc, obs_pc;
    ecause_t     obs_cause;
    bit          pc_unstable, valid_late, done;

`ifdef TRAP_SEQ_COUNT_EN
    localparam logic [31:0] CNT_AFTER3 = 32'd3;
`else
    localparam logic [31:0] CNT_AFTER3 = 32'd0;
`endif

    task automatic fire(input bit exc, input bit mret, input bit flush,
                        input logic [29:0] pc, input ecause_t cause,
                        input bit fe, input bit mem);
        @(posedge clk_core); #1;
        wb_exc = exc; wb_mret = mret; wb_flush = flush;
        wb_pc = pc; wb_exc_cause = cause; fe1_stall = fe; mem1_stall = mem;
        @(posedge clk_core); #1;
        wb_exc = 1'b0; wb_mret = 1'b0; wb_flush = 1'b0;
    endtask

    // Steps the sequence cycle by cycle, releases stalls at the requested
    // cycle and answers the redirect after rdy_delay cycles of valid.
    task automatic observe(input int rdy_delay, input int fe_hold, input int mem_hold,
                           input int budget, input bit stop_at_redirect);
        int vcnt = 0;
        bit hs = 0;
        commit_cyc = 0; flush_cyc = 0; redir_cyc = 0; end_cyc = 0;
        commits = 0; flushes = 0; to_first = 0;
        pc_unstable = 0; valid_late = 0; done = 0;
        obs_mepc = '0; obs_pc = '0; obs_cause = '0;
        for (int k = 1; k <= budget && !done; k++) begin
            @(negedge clk_core);
            if (hs) begin
                redirect_ready = 1'b0;
                hs = 0;
                if (redirect_valid) valid_late = 1;
            end
            if (k == fe_hold) fe1_stall = 1'b0;
            if (k == mem_hold) mem1_stall = 1'b0;
            if (drain_timeout && to_first == 0) to_first = k;
            if (csr_trap_we) begin
                commits++; commit_cyc = k;
                obs_mepc = csr_mepc_wdata; obs_cause = csr_mcause_wdata;
            end
            if (seq_flush) begin flushes++; flush_cyc = k; end
            if (!seq_busy) begin
                end_cyc = k; done = 1;
            end else if (redirect_valid) begin
                if (redir_cyc == 0) begin
                    redir_cyc = k; obs_pc = redirect_pc;
                end else if (redirect_pc !== obs_pc) begin
                    pc_unstable = 1;
                end
                if (stop_at_redirect) done = 1;
                else if (vcnt == rdy_delay) begin redirect_ready = 1'b1; hs = 1; end
                vcnt++;
            end
        end
        fe1_stall = 1'b0; mem1_stall = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_core);
        #1;
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", seq_busy); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b want 0", redirect_valid); end
        checks++; if (csr_trap_we !== 1'b0 || seq_flush !== 1'b0) begin errors++; $display("FAIL reset_strobes: got we=%0b fl=%0b want 0", csr_trap_we, seq_flush); end
        checks++; if (redirect_pc !== 30'h0 || csr_mepc_wdata !== 30'h0) begin errors++; $display("FAIL reset_data: got rpc=%0h mepc=%0h want 0", redirect_pc, csr_mepc_wdata); end
        checks++; if (drain_timeout !== 1'b0 || trap_count !== 32'd0) begin errors++; $display("FAIL reset_flags: got to=%0b cnt=%0d want 0", drain_timeout, trap_count); end
        #2 reset = 1'b0;
    endtask

    task automatic test_exc_basic();
        exp_t e;
        csr_mtvec = 30'h40; csr_mepc = 30'h0;
        exp_q.push_back('{1'b1, 30'h100, 4'd2, 30'h40, 4});
        fire(1, 0, 0, 30'h100, 4'd2, 0, 0);
        observe(2, 0, 0, 50, 0);
        e = exp_q.pop_front();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL exc_done: got %0b want 1", done); end
        checks++; if (commit_cyc !== 2 || commits !== 1) begin errors++; $display("FAIL exc_commit: got cyc=%0d n=%0d want cyc=2 n=1", commit_cyc, commits); end
        checks++; if (obs_mepc !== e.mepc || obs_cause !== e.cause) begin errors++; $display("FAIL exc_csr: got mepc=%0h cause=%0d want %0h/%0d", obs_mepc, obs_cause, e.mepc, e.cause); end
        checks++; if (flush_cyc !== 3 || flushes !== 1) begin errors++; $display("FAIL exc_flush: got cyc=%0d n=%0d want 3/1", flush_cyc, flushes); end
        checks++; if (redir_cyc !== e.lat || obs_pc !== e.pc) begin errors++; $display("FAIL exc_redirect: got cyc=%0d pc=%0h want %0d/%0h", redir_cyc, obs_pc, e.lat, e.pc); end
        checks++; if (end_cyc !== redir_cyc + 3 || pc_unstable || valid_late) begin errors++; $display("FAIL exc_release: got end=%0d unst=%0b late=%0b want end=%0d", end_cyc, pc_unstable, valid_late, redir_cyc + 3); end
        checks++; if (drain_timeout !== 1'b0) begin errors++; $display("FAIL exc_no_timeout: got %0b want 0", drain_timeout); end
    endtask

    task automatic test_mem_stall();
        exp_t e;
        exp_q.push_back('{1'b1, 30'h2A4, 4'd5, 30'h40, 13});
        fire(1, 0, 0, 30'h2A4, 4'd5, 0, 1);
        observe(0, 0, 10, 80, 0);
        e = exp_q.pop_front();
        checks++; if (commit_cyc - 1 !== 10 || commits !== 1) begin errors++; $display("FAIL stall_drain_len: got %0d n=%0d want 10 n=1", commit_cyc - 1, commits); end
        checks++; if (redir_cyc !== e.lat || obs_pc !== e.pc || obs_mepc !== e.mepc) begin errors++; $display("FAIL stall_redirect: got cyc=%0d pc=%0h mepc=%0h want %0d/%0h/%0h", redir_cyc, obs_pc, obs_mepc, e.lat, e.pc, e.mepc); end
    endtask

    task automatic test_priority();
        exp_t e;
        csr_mepc = 30'h200; csr_mtvec = 30'h40;
        exp_q.push_back('{1'b1, 30'h180, 4'd3, 30'h40, 4});
        fire(1, 1, 0, 30'h180, 4'd3, 0, 0);
        observe(0, 0, 0, 50, 0);
        e = exp_q.pop_front();
        checks++; if (obs_pc !== e.pc || redir_cyc !== e.lat) begin errors++; $display("FAIL prio_redirect: got pc=%0h cyc=%0d want %0h/%0d", obs_pc, redir_cyc, e.pc, e.lat); end
        checks++; if (commits !== 1) begin errors++; $display("FAIL prio_commits: got %0d want 1", commits); end
    endtask

    task automatic test_mret();
        exp_t e;
        csr_mepc = 30'h200;
        exp_q.push_back('{1'b0, 30'h0, 4'd0, 30'h200, 3});
        fire(0, 1, 0, 30'h55, 4'd0, 0, 0);
        csr_mepc = 30'h333;
        observe(1, 0, 0, 50, 0);
        e = exp_q.pop_front();
        checks++; if (obs_pc !== e.pc || redir_cyc !== e.lat) begin errors++; $display("FAIL mret_redirect: got pc=%0h cyc=%0d want %0h/%0d", obs_pc, redir_cyc, e.pc, e.lat); end
        checks++; if (commits !== 0 || flushes !== 1 || flush_cyc !== 2) begin errors++; $display("FAIL mret_strobes: got we=%0d fl=%0d flcyc=%0d want 0/1/2", commits, flushes, flush_cyc); end
    endtask

    task automatic test_flush_wrap();
        exp_t e;
        exp_q.push_back('{1'b0, 30'h0, 4'd0, 30'h0, 3});
        fire(0, 0, 1, 30'h3FFFFFFF, 4'd0, 0, 0);
        observe(0, 0, 0, 50, 0);
        e = exp_q.pop_front();
        checks++; if (obs_pc !== e.pc || redir_cyc !== e.lat) begin errors++; $display("FAIL flush_wrap: got pc=%0h cyc=%0d want %0h/%0d", obs_pc, redir_cyc, e.pc, e.lat); end
        checks++; if (commits !== 0 || end_cyc !== 4) begin errors++; $display("FAIL flush_no_we: got we=%0d end=%0d want 0/4", commits, end_cyc); end
    endtask

    task automatic test_timeout();
        fire(1, 0, 0, 30'h77, 4'd1, 1, 0);
        observe(0, 70, 0, 200, 0);
        checks++; if (to_first !== 64) begin errors++; $display("FAIL timeout_rise: got cycle %0d want 64", to_first); end
        checks++; if (commit_cyc !== 71 || done !== 1'b1) begin errors++; $display("FAIL timeout_wait: got commit=%0d done=%0b want 71/1", commit_cyc, done); end
        repeat (3) @(negedge clk_core);
        checks++; if (drain_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b want 1", drain_timeout); end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        @(posedge clk_core); #2 reset = 1'b1;
        #1;
        checks++; if (drain_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b want 0", drain_timeout); end
        @(posedge clk_core); #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fire(1, 0, 0, 30'h10 + 30'(i), 4'd4, 0, 0);
            observe(0, 0, 0, 50, 0);
        end
        @(negedge clk_core);
        checks++; if (trap_count !== CNT_AFTER3) begin errors++; $display("FAIL trap_count3: got %0d want %0d", trap_count, CNT_AFTER3); end
        fire(1, 0, 0, 30'h999, 4'd6, 0, 0);
        observe(0, 0, 0, 50, 1);
        checks++; if (redirect_valid !== 1'b1 || redir_cyc !== 4) begin errors++; $display("FAIL mid_redirect: got v=%0b cyc=%0d want 1/4", redirect_valid, redir_cyc); end
        #2 reset = 1'b1;
        #1;
        checks++; if (seq_busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 30'h0) begin errors++; $display("FAIL mid_reset_ctl: got busy=%0b v=%0b pc=%0h want 0", seq_busy, redirect_valid, redirect_pc); end
        checks++; if (csr_mepc_wdata !== 30'h0 || csr_mcause_wdata !== 4'd0 || trap_count !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got mepc=%0h cause=%0d cnt=%0d want 0", csr_mepc_wdata, csr_mcause_wdata, trap_count); end
        @(posedge clk_core); #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_core);
            if (seq_busy || redirect_valid || csr_trap_we || seq_flush) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got activity=%0b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_exc_basic();
        test_mem_stall();
        test_priority();
        test_mret();
        test_flush_wrap();
        test_timeout();
        test_reset_mid();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Controller that sequences the writeback boundary when an instruction retires with an exception, an mret, or a pipeline-flush request.
- Sits beside stage_write and the CSR file:
  - waits for in-flight fetch/memory bus transactions to drain;
  - commits trap CSRs;
  - flushes the pipeline;
  - issues a redirect handshake to fetch.
- Holds the pipeline via seq_busy until the redirect is accepted.

Parameters:
- DRAIN_MAX, 64, cycles allowed in DRAIN before drain_timeout is raised.
- CNT_W, 7, width of the drain cycle counter; must satisfy 2**CNT_W > DRAIN_MAX.

Ports:
- clk_core  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- wb_exc  in  1  retiring insn faulted.
- wb_exc_cause  in  ecause_t  cause for wb_exc.
- wb_flush  in  1  retiring insn requests flush (fence.i, CSR side effects).
- wb_mret  in  1  retiring insn is mret.
- wb_pc  in  [31:2]  pc of retiring insn.
- fe1_stall  in  1  fetch has an ongoing cache fill/evict.
- mem1_stall  in  1  memory stage has an ongoing cache fill/evict.
- csr_mtvec  in  [31:2]  trap vector base (direct mode).
- csr_mepc  in  [31:2]  return pc for mret.
- seq_busy  out  1  hold all pipeline stages; high in every state except IDLE.
- seq_flush  out  1  one-cycle squash of all in-flight pipeline state.
- csr_trap_we  out  1  one-cycle write strobe for mepc/mcause.
- csr_mepc_wdata  out  [31:2]  captured wb_pc.
- csr_mcause_wdata  out  ecause_t  captured cause.
- redirect_valid  out  1  new fetch pc valid.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  [31:2]  target pc.
- drain_timeout  out  1  sticky error flag.
- trap_count  out  32  trap counter; see Optional Feature.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; captured registers 0; drain_timeout cleared.
- States: IDLE, DRAIN, COMMIT, FLUSH, REDIRECT.
- Event priority in IDLE: wb_exc > wb_mret > wb_flush. Lower-priority simultaneous events are dropped.
- Capture in IDLE on any event:
  - kind (EXC/MRET/FLUSH);
  - wb_pc;
  - wb_exc_cause.
- Redirect target:
  - EXC: csr_mtvec.
  - MRET: csr_mepc, sampled at capture.
  - FLUSH: wb_pc+1 (next word, wraps modulo 2**30).
- Transitions:
  - IDLE -> DRAIN next edge on any event.
  - DRAIN: counter increments each cycle.
    - Exit condition is ~fe1_stall & ~mem1_stall.
    - Exit to COMMIT if kind=EXC, else to FLUSH.
    - When fe1_stall and mem1_stall are already low on entry, DRAIN lasts exactly 1 cycle.
  - COMMIT: csr_trap_we=1 for exactly 1 cycle -> FLUSH.
  - FLUSH: seq_flush=1 for exactly 1 cycle -> REDIRECT.
  - REDIRECT: redirect_valid=1 and redirect_pc stable until redirect_ready is sampled high -> IDLE.
    - The cycle redirect_ready is sampled high is the last busy cycle.
- Latency: event to redirect_valid with no drain stall:
  - EXC: 4 cycles (DRAIN, COMMIT, FLUSH, REDIRECT).
  - MRET/FLUSH: 3 cycles.
- Drain timeout:
  - If the counter reaches DRAIN_MAX while still in DRAIN, drain_timeout sets and stays set until reset.
  - Sequencing still waits for the drain to complete; the flag is report-only.
  - The counter saturates and clears on DRAIN exit.
- Events arriving while not in IDLE are ignored; seq_busy guarantees upstream holds them.
- Async reset mid-sequence aborts immediately. No CSR write or redirect is emitted after reset deasserts.
- seq_busy is registered (state != IDLE). It rises the cycle after the event and falls the cycle after the redirect handshake.

Optional Feature:
- Macro: TRAP_SEQ_COUNT_EN.
- Defined: trap_count increments by 1 on each COMMIT cycle and saturates at 32'hFFFFFFFF. Reset value 0.
- Undefined: trap_count is tied to 0 and no counter flops exist.

Decomposition:
- ecause_t is reused from the shared defines package.
- Add to the package:
  - trap_state_t enum for {IDLE, DRAIN, COMMIT, FLUSH, REDIRECT};
  - trap_kind_t enum {TK_EXC, TK_MRET, TK_FLUSH}.
- Single flat module; no sub-module is warranted. The drain counter stays inline.

Test Plan:
- EXC, no stalls: wb_exc=1, cause=2, wb_pc=30'h100, mtvec=30'h40.
  - csr_trap_we pulses with mepc=30'h100, mcause=2.
  - redirect_valid appears on cycle 4 with redirect_pc=30'h40.
  - seq_busy falls one cycle after redirect_ready.
- EXC during mem1_stall held 10 cycles: COMMIT occurs only after mem1_stall falls; DRAIN lasts exactly 10 cycles.
- Simultaneous wb_exc=1 and wb_mret=1 with mepc=30'h200, mtvec=30'h40: redirect_pc=30'h40 and csr_trap_we fires once.
- FLUSH at wb_pc=30'h3FFFFFFF: redirect_pc=30'h0 (wrap); csr_trap_we never asserts.
- DRAIN_MAX=64 with fe1_stall held 70 cycles: drain_timeout rises at cycle 64 of DRAIN and stays high after the sequence completes until reset.
- Reset asserted while in REDIRECT with redirect_ready=0: all outputs 0 immediately.
  - With TRAP_SEQ_COUNT_EN defined, 3 back-to-back EXC sequences before the reset give trap_count=3; after reset it reads 0.
